// File: rtl/rice_core_pkg.sv
// Shared types and constants for the rice core register-hazard scoreboard.
package rice_core_pkg;

    localparam int RICE_CORE_MAX_PENDING = 3;

    function automatic int count_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    typedef logic [$clog2(RICE_CORE_MAX_PENDING + 1)-1:0] rice_core_scoreboard_count;

endpackage

// File: rtl/rice_core_scoreboard_counter.sv
// Saturating up/down pending-write counter for one architectural register.
module rice_core_scoreboard_counter
    import rice_core_pkg::*;
#(
    parameter int MAX_PENDING = RICE_CORE_MAX_PENDING,
    parameter int W           = count_width(MAX_PENDING)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         over,
    output logic         under
);

    localparam logic [W-1:0] MAX_C = W'(MAX_PENDING);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Simultaneous inc/dec cancel, so neither saturation case applies then.
    always_comb begin
        count_d = count_q;
        over    = inc && !dec && (count_q == MAX_C);
        under   = dec && !inc && (count_q == '0);
        if (inc && !dec && !over) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && !under) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rice_core_scoreboard.sv
// Register-hazard scoreboard beside ID: counts in-flight writes to x1..x31
// and raises a combinational stall on RAW, destination saturation or serialization.
module rice_core_scoreboard
    import rice_core_pkg::*;
#(
    parameter int MAX_PENDING = RICE_CORE_MAX_PENDING
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic       i_flush,
    input  logic       i_dec_valid,
    input  logic [4:0] i_dec_rs1,
    input  logic [4:0] i_dec_rs2,
    input  logic [4:0] i_dec_rd,
    input  logic       i_dec_serialize,
    input  logic       i_issue_valid,
    input  logic [4:0] i_issue_rd,
    input  logic       i_wb_valid,
    input  logic [4:0] i_wb_rd,
    output logic       o_stall,
    output logic       o_idle,
    output logic       o_error
);

    localparam int           CW    = count_width(MAX_PENDING);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_PENDING);

    logic          issue_ev;
    logic          wb_ev;
    logic [CW-1:0] cnt [1:31];
    logic [CW-1:0] eff [0:31];
    logic [31:1]   over;
    logic [31:1]   under;
    logic          any_pend;
    logic          all_zero;
    logic          hazard;
    logic          err_q;
    logic          err_d;

    assign issue_ev = i_issue_valid && i_enable && !i_flush && (i_issue_rd != 5'd0);
    assign wb_ev    = i_wb_valid && (i_wb_rd != 5'd0);

    for (genvar g = 1; g < 32; g++) begin : g_cnt
        rice_core_scoreboard_counter #(
            .MAX_PENDING (MAX_PENDING),
            .W           (CW)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .inc     (issue_ev && (i_issue_rd == 5'(g))),
            .dec     (wb_ev && (i_wb_rd == 5'(g))),
            .count   (cnt[g]),
            .over    (over[g]),
            .under   (under[g])
        );
    end

    // eff bypasses this cycle's writeback; x0 is pinned at zero so the
    // decode indices can select eff directly. A writeback against an empty
    // counter is an error, not a release, so eff clamps at zero.
    always_comb begin
        eff[0]   = '0;
        any_pend = 1'b0;
        all_zero = 1'b1;
        for (int r = 1; r < 32; r++) begin
            if (wb_ev && (i_wb_rd == 5'(r)) && (cnt[r] != '0)) begin
                eff[r] = cnt[r] - CW'(1);
            end else begin
                eff[r] = cnt[r];
            end
            if (eff[r] != '0) begin
                any_pend = 1'b1;
            end
            if (cnt[r] != '0) begin
                all_zero = 1'b0;
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        if ((i_dec_rs1 != 5'd0) && (eff[i_dec_rs1] != '0)) begin
            hazard = 1'b1;
        end
        if ((i_dec_rs2 != 5'd0) && (eff[i_dec_rs2] != '0)) begin
            hazard = 1'b1;
        end
        if ((i_dec_rd != 5'd0) && (eff[i_dec_rd] == MAX_C)) begin
            hazard = 1'b1;
        end
        if (i_dec_serialize && any_pend) begin
            hazard = 1'b1;
        end
    end

    assign err_d = err_q || (|over) || (|under);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_stall = !i_enable || (i_dec_valid && hazard);
    assign o_idle  = all_zero;
    assign o_error = err_q;

endmodule

// File: tb/tb_rice_core_scoreboard.sv
// Directed scoreboard bench for rice_core_scoreboard with default MAX_PENDING=3.
module tb_rice_core_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       flush;
    logic       dec_valid;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [4:0] dec_rd;
    logic       dec_ser;
    logic       iss_valid;
    logic [4:0] iss_rd;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       stall;
    logic       idle;
    logic       error;

    typedef struct {
        string name;
        logic  stall;
        logic  idle;
        logic  error;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    rice_core_scoreboard dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_enable        (enable),
        .i_flush         (flush),
        .i_dec_valid     (dec_valid),
        .i_dec_rs1       (dec_rs1),
        .i_dec_rs2       (dec_rs2),
        .i_dec_rd        (dec_rd),
        .i_dec_serialize (dec_ser),
        .i_issue_valid   (iss_valid),
        .i_issue_rd      (iss_rd),
        .i_wb_valid      (wb_valid),
        .i_wb_rd         (wb_rd),
        .o_stall         (stall),
        .o_idle          (idle),
        .o_error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: each queued expectation belongs to the cycle it was pushed in.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, idle, error} !== {e.stall, e.idle, e.error}) begin
                n_bad++;
                $display("FAIL %s: stall/idle/error got %b%b%b expected %b%b%b",
                         e.name, stall, idle, error, e.stall, e.idle, e.error);
            end
        end
    end

    task automatic clear_inputs();
        enable    = 1'b1;
        flush     = 1'b0;
        dec_valid = 1'b0;
        dec_rs1   = 5'd0;
        dec_rs2   = 5'd0;
        dec_rd    = 5'd0;
        dec_ser   = 1'b0;
        iss_valid = 1'b0;
        iss_rd    = 5'd0;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
    endtask

    task automatic cyc(input string nm, input logic st, input logic idl, input logic er);
        exp_t e;
        e.name  = nm;
        e.stall = st;
        e.idle  = idl;
        e.error = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        dec_valid = 1'b1;
        dec_rs1   = rs1;
        dec_rs2   = rs2;
        dec_rd    = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        cyc("reset_state", 1'b0, 1'b1, 1'b0);
        enable = 1'b0;
        cyc("reset_enable_low", 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Back-to-back RAW
        issue(5'd5);                 cyc("raw_issue", 1'b0, 1'b1, 1'b0);
        dec(5'd5, 5'd0, 5'd0);       cyc("raw_dep_c1", 1'b1, 1'b0, 1'b0);
        dec(5'd5, 5'd0, 5'd0);       cyc("raw_dep_c2", 1'b1, 1'b0, 1'b0);
        dec(5'd5, 5'd0, 5'd0); wb(5'd5); cyc("raw_wb_bypass", 1'b0, 1'b0, 1'b0);
        cyc("raw_idle_after", 1'b0, 1'b1, 1'b0);
        issue(5'd6);                 cyc("rs2_issue", 1'b0, 1'b1, 1'b0);
        dec(5'd1, 5'd6, 5'd0);       cyc("rs2_dep", 1'b1, 1'b0, 1'b0);
        dec(5'd1, 5'd2, 5'd6);       cyc("rd_not_sat", 1'b0, 1'b0, 1'b0);
        wb(5'd6);                    cyc("rs2_wb", 1'b0, 1'b0, 1'b0);
        cyc("rs2_idle", 1'b0, 1'b1, 1'b0);

        // x0 handling
        issue(5'd0);                 cyc("x0_issue", 1'b0, 1'b1, 1'b0);
        cyc("x0_idle", 1'b0, 1'b1, 1'b0);
        dec(5'd0, 5'd0, 5'd0);       cyc("x0_dec", 1'b0, 1'b1, 1'b0);
        wb(5'd0);                    cyc("x0_wb", 1'b0, 1'b1, 1'b0);
        cyc("x0_wb_no_err", 1'b0, 1'b1, 1'b0);

        // Flush and enable
        issue(5'd3); flush = 1'b1;   cyc("flush_issue", 1'b0, 1'b1, 1'b0);
        dec(5'd3, 5'd0, 5'd0);       cyc("flush_dropped", 1'b0, 1'b1, 1'b0);
        issue(5'd3);                 cyc("flushwb_issue", 1'b0, 1'b1, 1'b0);
        issue(5'd3); wb(5'd3); flush = 1'b1; cyc("flushwb_both", 1'b0, 1'b0, 1'b0);
        cyc("flushwb_idle", 1'b0, 1'b1, 1'b0);
        issue(5'd8); enable = 1'b0;  cyc("disable_issue", 1'b1, 1'b1, 1'b0);
        dec(5'd8, 5'd0, 5'd0);       cyc("disable_dropped", 1'b0, 1'b1, 1'b0);

        // Serializing instruction
        issue(5'd4);                 cyc("ser_issue", 1'b0, 1'b1, 1'b0);
        dec(5'd0, 5'd0, 5'd0); dec_ser = 1'b1; cyc("ser_wait1", 1'b1, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd0); dec_ser = 1'b1; cyc("ser_wait2", 1'b1, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd0); dec_ser = 1'b1; wb(5'd4); cyc("ser_release", 1'b0, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd0); dec_ser = 1'b1; cyc("ser_clear", 1'b0, 1'b1, 1'b0);

        // Simultaneous events and underflow
        issue(5'd9);                 cyc("sim_issue", 1'b0, 1'b1, 1'b0);
        issue(5'd9); wb(5'd9);       cyc("sim_both", 1'b0, 1'b0, 1'b0);
        dec(5'd9, 5'd0, 5'd0);       cyc("sim_count_kept", 1'b1, 1'b0, 1'b0);
        wb(5'd9);                    cyc("sim_wb", 1'b0, 1'b0, 1'b0);
        cyc("sim_idle", 1'b0, 1'b1, 1'b0);
        wb(5'd9);                    cyc("under_wb", 1'b0, 1'b1, 1'b0);
        dec(5'd9, 5'd0, 5'd0);       cyc("under_err", 1'b0, 1'b1, 1'b1);

        // Async reset mid-sequence
        issue(5'd10);                cyc("rst_pre_issue", 1'b0, 1'b1, 1'b1);
        dec(5'd10, 5'd0, 5'd0);      cyc("rst_pre_dep", 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;                cyc("rst_async", 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1; wb(5'd10);     cyc("rst_late_wb", 1'b0, 1'b1, 1'b0);
        cyc("rst_late_wb_err", 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;                cyc("rst_again", 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;

        // Saturation
        issue(5'd7);                 cyc("sat_issue1", 1'b0, 1'b1, 1'b0);
        issue(5'd7);                 cyc("sat_issue2", 1'b0, 1'b0, 1'b0);
        issue(5'd7);                 cyc("sat_issue3", 1'b0, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd7);       cyc("sat_rd_stall", 1'b1, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd7); wb(5'd7); cyc("sat_rd_bypass", 1'b0, 1'b0, 1'b0);
        issue(5'd7);                 cyc("sat_refill", 1'b0, 1'b0, 1'b0);
        issue(5'd7);                 cyc("sat_overflow", 1'b0, 1'b0, 1'b0);
        dec(5'd0, 5'd0, 5'd7);       cyc("sat_over_err", 1'b1, 1'b0, 1'b1);
        wb(5'd7);                    cyc("sat_drain1", 1'b0, 1'b0, 1'b1);
        wb(5'd7);                    cyc("sat_drain2", 1'b0, 1'b0, 1'b1);
        wb(5'd7);                    cyc("sat_drain3", 1'b0, 1'b0, 1'b1);
        cyc("sat_drained", 1'b0, 1'b1, 1'b1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rice_core_scoreboard.md
# rice_core_scoreboard

Register-hazard scoreboard for the rice core pipeline. It sits beside the ID stage and tracks the outstanding writes to each of x1..x31 between issue out of ID and writeback. It raises a combinational stall toward IF/ID whenever the instruction being decoded reads a register that has a pending write. It also stalls when that instruction's destination counter is saturated, or when the instruction is serializing and any write is still pending.

## Interface
- MAX_PENDING, default 3: maximum in-flight writes per register, range 1..7.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset. One clock; asynchronous, active-low.
- i_enable  in  1  core enable; when 0, o_stall=1 and issue is ignored.
- i_flush  in  1  pipeline flush; issue is ignored in the same cycle.
- i_dec_valid  in  1  decode slot holds a valid instruction.
- i_dec_rs1  in  5  source 1 index; 0 means unused.
- i_dec_rs2  in  5  source 2 index; 0 means unused.
- i_dec_rd  in  5  destination index; 0 means no write.
- i_dec_serialize  in  1  fence, fence.i, csr, ecall, ebreak or mret in decode.
- i_issue_valid  in  1  ID result accepted downstream this cycle.
- i_issue_rd  in  5  destination of the accepted instruction.
- i_wb_valid  in  1  register-file write this cycle.
- i_wb_rd  in  5  register being written.
- o_stall  out  1  hold IF/ID this cycle (combinational).
- o_idle  out  1  all counters are zero (registered state).
- o_error  out  1  sticky underflow/overflow flag.

## Operation
- State:
  - count[r] for r=1..31, each $clog2(MAX_PENDING+1) bits, unsigned.
  - err, 1 bit.
  - There is no counter for x0; writes to x0 are never tracked.
- Issue event: i_issue_valid && i_enable && !i_flush && i_issue_rd!=0.
- Writeback event: i_wb_valid && i_wb_rd!=0. Writebacks are counted regardless of i_flush and i_enable, so flushed-but-already-issued writes still retire.
- Counter update for each r:
  - +1 if issue hits r.
  - -1 if writeback hits r.
  - Both in the same cycle: the count is unchanged.
- Underflow: a writeback to r with count[r]==0 and no simultaneous issue to r. The count stays 0 and err is set.
- Overflow: an issue to r with count[r]==MAX_PENDING and no simultaneous writeback to r. The count stays at MAX_PENDING and err is set.
- err clears only on reset.
- Effective pending value: eff[r] = count[r] minus 1 if a writeback to r occurs this cycle, else count[r]. This is bypass-aware, because the register file is written in the same cycle.
- o_stall = !i_enable, OR i_dec_valid && any of the following:
  - rs1!=0 && eff[rs1]!=0
  - rs2!=0 && eff[rs2]!=0
  - rd!=0 && eff[rd]==MAX_PENDING
  - i_dec_serialize && any eff[r]!=0
- o_idle = all count[r]==0. It does not look at the current writeback.
- o_error = err.

## Timing
- Reset: all counts 0, err=0. Reset outputs: o_idle=1, o_error=0, o_stall=!i_enable.
- Reset asserted mid-operation clears all state immediately; pending writebacks arriving afterward are reported as underflow.
- o_stall has zero-cycle latency from every input.
- A counter change is visible in o_idle and in eff one cycle after the event edge.
- An issue in cycle N makes the decode of a dependent instruction stall from cycle N+1.
- A writeback in cycle M releases the stall in cycle M itself.
- Flush in the same cycle as a writeback: the writeback is applied and the issue is dropped.

## Structure
- rice_core_pkg holds:
  - typedef rice_core_scoreboard_count, sized from RICE_CORE_MAX_PENDING.
  - constant RICE_CORE_MAX_PENDING = 3, used as the default for MAX_PENDING.
- Sub-module rice_core_scoreboard_counter implements one saturating up/down counter.
  - Inputs: inc, dec. Outputs: count, over, under.
  - Instantiated 31 times via a generate loop.
  - The top level ORs the over/under outputs into err and builds eff, o_stall and o_idle.
- Target size: about 150-250 lines total.

## Test plan
- Back-to-back RAW:
  - Cycle 0: issue rd=5.
  - Cycle 1: decode rs1=5 -> o_stall=1.
  - Cycle 3: wb rd=5 -> o_stall=0 in cycle 3, and o_idle=1 in cycle 4.
- Saturation with MAX_PENDING=3:
  - Three issues to rd=7 -> decode rd=7 gives o_stall=1.
  - A fourth forced issue -> count stays 3 and o_error=1.
- Simultaneous events and underflow:
  - Same-cycle issue and wb to x9 with count 1 -> count stays 1.
  - wb to x9 with count 0 -> o_error=1 and count 0.
- x0 handling:
  - Issue rd=0 -> o_idle stays 1.
  - Decode rs1=0, rs2=0 -> o_stall=0.
- Flush and enable:
  - i_flush=1 with issue rd=3 -> count[3] stays 0.
  - i_enable=0 -> o_stall=1 and issue is ignored.
- Serializing instruction and reset:
  - Pending x4 plus i_dec_serialize -> o_stall=1 until wb x4.
  - Async reset mid-sequence -> counts 0, o_idle=1, o_error=0.
